// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings, datapath width and the
// multiply-sequencer state type.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_NEG_LO,
      S_NEG_HI,
      S_DONE
   } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-add 32x32 multiplier that borrows the shared ALU for its adds.
// Define ALU_MULSEQ_SIGNED_EN to enable signed multiply via sign correction.
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   input  logic            req_signed,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_lo,
   output logic [XLEN-1:0] resp_hi,
   output logic            busy,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_c
);

   mul_state_t state_q, state_d;
   logic [XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic neg_q, neg_d;
   logic lo_zero_q, lo_zero_d;
   logic [XLEN-1:0] a_in, b_in;
   logic neg_in;

`ifdef ALU_MULSEQ_SIGNED_EN
   // Magnitude conversion is local; |0x80000000| stays 0x80000000.
   always_comb begin
      a_in   = req_a;
      b_in   = req_b;
      neg_in = 1'b0;
      if (req_signed) begin
         a_in   = req_a[XLEN-1] ? (~req_a + 1'b1) : req_a;
         b_in   = req_b[XLEN-1] ? (~req_b + 1'b1) : req_b;
         neg_in = req_a[XLEN-1] ^ req_b[XLEN-1];
      end
   end
`else
   logic unused_signed;
   assign unused_signed = req_signed;
   assign a_in   = req_a;
   assign b_in   = req_b;
   assign neg_in = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         hi_q      <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         lo_zero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         hi_q      <= hi_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         lo_zero_q <= lo_zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (req_valid) state_d = S_CALC;
         S_CALC: begin
            if (count_q == CNT_W'(XLEN-1))
               state_d = neg_q ? S_NEG_LO : S_DONE;
         end
         S_NEG_LO: state_d = S_NEG_HI;
         S_NEG_HI: state_d = S_DONE;
         S_DONE:   if (resp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      hi_d      = hi_q;
      count_d   = count_q;
      neg_d     = neg_q;
      lo_zero_d = lo_zero_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               mcand_d  = a_in;
               mplier_d = b_in;
               hi_d     = '0;
               count_d  = '0;
               neg_d    = neg_in;
            end
         end
         // 65-bit right shift of {carry, sum, multiplier}
         S_CALC: begin
            {hi_d, mplier_d} = {alu_c, alu_result, mplier_q[XLEN-1:1]};
            count_d = count_q + 1'b1;
         end
`ifdef ALU_MULSEQ_SIGNED_EN
         S_NEG_LO: begin
            mplier_d  = alu_result;
            lo_zero_d = (mplier_q == '0);
         end
         S_NEG_HI: hi_d = lo_zero_q ? alu_result : ~hi_q;
`endif
         default: ;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == S_IDLE);
      resp_valid = (state_q == S_DONE);
      busy       = 1'b0;
      alu_a      = '0;
      alu_b      = '0;
      alu_ctrl   = ALU_ADD;
      unique case (state_q)
         S_CALC: begin
            busy  = 1'b1;
            alu_a = hi_q;
            alu_b = mplier_q[0] ? mcand_q : '0;
         end
`ifdef ALU_MULSEQ_SIGNED_EN
         S_NEG_LO: begin
            busy     = 1'b1;
            alu_b    = mplier_q;
            alu_ctrl = ALU_SUB;
         end
         S_NEG_HI: begin
            busy = 1'b1;
            if (lo_zero_q) begin
               alu_b    = hi_q;
               alu_ctrl = ALU_SUB;
            end
         end
`endif
         default: ;
      endcase
   end

   assign resp_lo = mplier_q;
   assign resp_hi = hi_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU beside it.
module tb_alu_mul_sequencer;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic req_valid, req_ready, req_signed;
   logic [31:0] req_a, req_b;
   logic resp_valid, resp_ready;
   logic [31:0] resp_lo, resp_hi;
   logic busy;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0] alu_ctrl;
   logic alu_c;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_mul_sequencer dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_lo(resp_lo), .resp_hi(resp_hi), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_c(alu_c)
   );

   always_comb begin
      alu_result = '0;
      alu_c      = 1'b0;
      case (alu_ctrl)
         4'b0000: {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
         4'b0001: alu_result = alu_a - alu_b;
         default: ;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns just after the accepting edge (first CALC cycle).
   task automatic start_req(input logic [31:0] a, input logic [31:0] b,
                            input logic s);
      req_a      = a;
      req_b      = b;
      req_signed = s;
      req_valid  = 1'b1;
      tick();
      req_valid  = 1'b0;
   endtask

   task automatic wait_resp(output int lat, output logic ctrl_ok);
      lat     = 1;
      ctrl_ok = 1'b1;
      while (!resp_valid && lat < 60) begin
         if (busy && alu_ctrl !== 4'b0000) ctrl_ok = 1'b0;
         tick();
         lat++;
      end
   endtask

   int lat;
   logic ok;
   logic [31:0] lo_s, hi_s;

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req_a = '0;
      req_b = '0;
      req_signed = 1'b0;
      resp_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_resp", {resp_hi, resp_lo}, 64'd0);
      chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
      chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);

      // 3 * 5
      start_req(32'd3, 32'd5, 1'b0);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_req_ready", 64'(req_ready), 64'd0);
      chk("t1_first_ab", {alu_a, alu_b}, {32'd0, 32'd3});
      wait_resp(lat, ok);
      chk("t1_latency", 64'(lat), 64'd33);
      chk("t1_ctrl_add", 64'(ok), 64'd1);
      chk("t1_product", {resp_hi, resp_lo}, 64'h0000_0000_0000_000F);
      chk("t1_done_busy", 64'(busy), 64'd0);
      tick();
      chk("t1_back_idle", 64'(req_ready), 64'd1);

      // all-ones squared: carry on every iteration
      start_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      wait_resp(lat, ok);
      chk("t2_latency", 64'(lat), 64'd33);
      chk("t2_product", {resp_hi, resp_lo}, 64'hFFFF_FFFE_0000_0001);
      tick();

      // stalled response
      resp_ready = 1'b0;
      start_req(32'h0001_0000, 32'h0001_0000, 1'b0);
      wait_resp(lat, ok);
      chk("t3_latency", 64'(lat), 64'd33);
      chk("t3_product", {resp_hi, resp_lo}, 64'h0000_0001_0000_0000);
      lo_s = resp_lo;
      hi_s = resp_hi;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (resp_valid !== 1'b1 || resp_lo !== lo_s || resp_hi !== hi_s ||
             req_ready !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      end
      chk("t3_stall_stable", 64'(ok), 64'd1);
      resp_ready = 1'b1;
      tick();
      chk("t3_post_valid", 64'(resp_valid), 64'd0);
      chk("t3_post_ready", 64'(req_ready), 64'd1);

      // reset mid-CALC at iteration 10
      start_req(32'h1234_5678, 32'h0000_FFFF, 1'b0);
      for (int i = 0; i < 9; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_req_ready", 64'(req_ready), 64'd1);
      chk("t4_resp_valid", 64'(resp_valid), 64'd0);
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_alu_ab", {alu_a, alu_b}, 64'd0);
      chk("t4_alu_ctrl", 64'(alu_ctrl), 64'd0);
      start_req(32'd7, 32'd6, 1'b0);
      wait_resp(lat, ok);
      chk("t4_latency", 64'(lat), 64'd33);
      chk("t4_product", {resp_hi, resp_lo}, 64'd42);
      tick();

      // req_signed has no effect in the unsigned build
`ifndef ALU_MULSEQ_SIGNED_EN
      start_req(32'hFFFF_FFFE, 32'd3, 1'b1);
      wait_resp(lat, ok);
      chk("t5_latency", 64'(lat), 64'd33);
      chk("t5_product", {resp_hi, resp_lo}, 64'h0000_0002_FFFF_FFFA);
      tick();
`else
      start_req(32'hFFFF_FFFD, 32'd5, 1'b1);
      wait_resp(lat, ok);
      chk("s1_latency", 64'(lat), 64'd35);
      chk("s1_product", {resp_hi, resp_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      tick();
      start_req(32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1);
      wait_resp(lat, ok);
      chk("s2_latency", 64'(lat), 64'd33);
      chk("s2_product", {resp_hi, resp_lo}, 64'd6);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
